mem_sequencer: RTL and testbench

Parametrised memory-bus cycle sequencer that takes over the hard-wired fetch and LDW/STW bus phases from the CPU control FSM. The control FSM issues a one-cycle request (fetch, load or store). The block then drives the address-latch, chip-select, output-enable and write strobes, the pad-enable and bus-buffer signals, the PC/ALU address-source enables and the IR/register write pulses, and signals completion. Wait states are set by parameter. An optional external Ready handshake with timeout is added by macro.

---
 rtl/mem_sequencer_if.sv | 42 ++++
 rtl/mem_sequencer.sv | 150 +++++++++++++++
 tb/tb_mem_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_sequencer_if.sv
// Request/strobe bundle between the CPU control FSM (master) and mem_sequencer (slave).
// Ready exists only when MEM_READY_EN is defined.
interface mem_sequencer_if;
   logic       Req;
   logic [1:0] ReqKind;
`ifdef MEM_READY_EN
   logic       Ready;
`endif
   logic       Busy;
   logic       Done;
   logic       BusErr;
   logic       PcEn;
   logic       AluEn;
   logic       ALE;
   logic       nME;
   logic       nOE;
   logic       nWE;
   logic       ENB;
   logic       MemEn;
   logic       IrWe;
   logic       LoadWe;

`ifdef MEM_READY_EN
   modport master (
      output Req, ReqKind, Ready,
      input  Busy, Done, BusErr, PcEn, AluEn, ALE, nME, nOE, nWE, ENB, MemEn, IrWe, LoadWe
   );
   modport slave (
      input  Req, ReqKind, Ready,
      output Busy, Done, BusErr, PcEn, AluEn, ALE, nME, nOE, nWE, ENB, MemEn, IrWe, LoadWe
   );
`else
   modport master (
      output Req, ReqKind,
      input  Busy, Done, BusErr, PcEn, AluEn, ALE, nME, nOE, nWE, ENB, MemEn, IrWe, LoadWe
   );
   modport slave (
      input  Req, ReqKind,
      output Busy, Done, BusErr, PcEn, AluEn, ALE, nME, nOE, nWE, ENB, MemEn, IrWe, LoadWe
   );
`endif
endinterface

// File: rtl/mem_sequencer.sv
// Fetch/LDW/STW bus-cycle sequencer with parameterised wait states.
// MEM_READY_EN adds an external Ready handshake with timeout and BusErr reporting.
module mem_sequencer #(
   parameter int unsigned WAIT_STATES   = 0,
   parameter int unsigned READY_TIMEOUT = 15
) (
   input logic            Clock,
   input logic            nReset,
   mem_sequencer_if.slave bus
);
   localparam int unsigned CNT_MAX = (WAIT_STATES > READY_TIMEOUT) ? WAIT_STATES : READY_TIMEOUT;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ACCESS, S_LATCH, S_FINISH} state_t;
   typedef enum logic [1:0] {K_FETCH = 2'b00, K_LOAD = 2'b01, K_STORE = 2'b10, K_RSVD = 2'b11} kind_t;

   state_t        state_q, state_d;
   kind_t         kind_q, kind_d;
   logic [CW-1:0] wait_q, wait_d;
   logic          accept;
   logic          is_store;
`ifdef MEM_READY_EN
   logic [CW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;
`endif

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= S_IDLE;
         kind_q  <= K_FETCH;
         wait_q  <= '0;
`ifdef MEM_READY_EN
         tmo_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         wait_q  <= wait_d;
`ifdef MEM_READY_EN
         tmo_q   <= tmo_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      wait_d   = wait_q;
`ifdef MEM_READY_EN
      tmo_d    = tmo_q;
      err_d    = err_q;
`endif
      accept   = bus.Req && (bus.ReqKind != K_RSVD);
      is_store = (kind_q == K_STORE);

      bus.Busy   = 1'b1;
      bus.Done   = 1'b0;
      bus.BusErr = 1'b0;
      bus.PcEn   = 1'b0;
      bus.AluEn  = 1'b0;
      bus.ALE    = 1'b0;
      bus.nME    = 1'b1;
      bus.nOE    = 1'b1;
      bus.nWE    = 1'b1;
      bus.ENB    = 1'b0;
      bus.MemEn  = 1'b0;
      bus.IrWe   = 1'b0;
      bus.LoadWe = 1'b0;

      case (state_q)
         S_IDLE: begin
            bus.Busy = 1'b0;
            if (accept) begin
               state_d = S_ADDR;
               kind_d  = kind_t'(bus.ReqKind);
            end
         end
         S_ADDR: begin
            bus.ALE   = 1'b1;
            bus.PcEn  = (kind_q == K_FETCH);
            bus.AluEn = (kind_q != K_FETCH);
            state_d   = S_ACCESS;
            wait_d    = CW'(WAIT_STATES);
`ifdef MEM_READY_EN
            tmo_d     = CW'(READY_TIMEOUT);
            err_d     = 1'b0;
`endif
         end
         S_ACCESS: begin
            bus.nME = 1'b0;
            if (is_store) begin
               bus.nWE   = 1'b0;
               bus.AluEn = 1'b1;
            end else begin
               bus.nOE   = 1'b0;
               bus.MemEn = 1'b1;
            end
            // Wait states first; Ready is only consulted once they are exhausted.
            if (wait_q != '0) begin
               wait_d = wait_q - CW'(1);
            end else begin
`ifdef MEM_READY_EN
               if (bus.Ready) begin
                  state_d = S_LATCH;
               end else if (tmo_q == '0) begin
                  state_d = S_LATCH;
                  err_d   = 1'b1;
               end else begin
                  tmo_d = tmo_q - CW'(1);
               end
`else
               state_d = S_LATCH;
`endif
            end
         end
         S_LATCH: begin
            bus.nME = 1'b0;
            if (is_store) begin
               bus.AluEn = 1'b1;
            end else begin
               bus.nOE   = 1'b0;
               bus.MemEn = 1'b1;
               bus.ENB   = 1'b1;
            end
            state_d = S_FINISH;
         end
         S_FINISH: begin
            bus.Done   = 1'b1;
`ifdef MEM_READY_EN
            bus.BusErr = err_q;
`endif
            bus.IrWe   = (kind_q == K_FETCH);
            bus.LoadWe = (kind_q == K_LOAD);
            bus.MemEn  = !is_store;
            if (accept) begin
               state_d = S_ADDR;
               kind_d  = kind_t'(bus.ReqKind);
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            bus.Busy = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_mem_sequencer.sv
// Random-stimulus scoreboard bench for mem_sequencer: two instances (0 and 3 wait states)
// checked per cycle against a transaction-schedule model, plus a Done-event queue.
module tb_mem_sequencer;
   localparam int unsigned WS0  = 0;
   localparam int unsigned WS1  = 3;
   localparam int unsigned RT   = 4;
   localparam int          NCYC = 700;
   localparam int          ASZ  = NCYC + 64;
   localparam int P_IDLE = 0, P_ADDR = 1, P_ACC = 2, P_LAT = 3, P_FIN = 4;
   // {Busy,Done,BusErr,PcEn,AluEn,ALE,nME,nOE,nWE,ENB,MemEn,IrWe,LoadWe}
   localparam logic [12:0] IDLE_V = 13'b0_0_0_0_0_0_1_1_1_0_0_0_0;

   logic clk = 1'b0;
   logic nReset = 1'b0;
   always #5 clk = ~clk;

   mem_sequencer_if bus0();
   mem_sequencer_if bus1();

   mem_sequencer #(.WAIT_STATES(WS0), .READY_TIMEOUT(RT)) dut0 (.Clock(clk), .nReset(nReset), .bus(bus0));
   mem_sequencer #(.WAIT_STATES(WS1), .READY_TIMEOUT(RT)) dut1 (.Clock(clk), .nReset(nReset), .bus(bus1));

   logic [12:0] vec0, vec1;
   assign vec0 = {bus0.Busy, bus0.Done, bus0.BusErr, bus0.PcEn, bus0.AluEn, bus0.ALE, bus0.nME,
                  bus0.nOE, bus0.nWE, bus0.ENB, bus0.MemEn, bus0.IrWe, bus0.LoadWe};
   assign vec1 = {bus1.Busy, bus1.Done, bus1.BusErr, bus1.PcEn, bus1.AluEn, bus1.ALE, bus1.nME,
                  bus1.nOE, bus1.nWE, bus1.ENB, bus1.MemEn, bus1.IrWe, bus1.LoadWe};

   typedef struct {
      int cyc;
      int kind;
      bit err;
   } done_t;

   int    ph   [2][ASZ];
   int    knd  [2][ASZ];
   bit    erra [2][ASZ];
   bit    rdy  [ASZ];
   done_t dq0[$];
   done_t dq1[$];
   int    tests = 0;
   int    fails = 0;
   int    cur_cyc = 0;

   // Expected pins for one bus phase, straight from the per-phase strobe rules.
   function automatic logic [12:0] expect_vec(int p, int k, bit e);
      logic busy = 1'b0, done = 1'b0, berr = 1'b0, pc = 1'b0, alu = 1'b0, ale = 1'b0;
      logic nme = 1'b1, noe = 1'b1, nwe = 1'b1, enb = 1'b0, men = 1'b0, irwe = 1'b0, ldwe = 1'b0;
      busy = (p != P_IDLE);
      case (p)
         P_ADDR: begin ale = 1'b1; pc = (k == 0); alu = (k != 0); end
         P_ACC: begin
            nme = 1'b0;
            if (k == 2) begin nwe = 1'b0; alu = 1'b1; end
            else begin noe = 1'b0; men = 1'b1; end
         end
         P_LAT: begin
            nme = 1'b0;
            if (k == 2) alu = 1'b1;
            else begin noe = 1'b0; men = 1'b1; enb = 1'b1; end
         end
         P_FIN: begin
            done = 1'b1; berr = e;
            irwe = (k == 0); ldwe = (k == 1); men = (k != 2);
         end
         default: ;
      endcase
      return {busy, done, berr, pc, alu, ale, nme, noe, nwe, enb, men, irwe, ldwe};
   endfunction

   // Lay out the whole bus cycle of a request accepted at the end of cycle c.
   task automatic schedule(input int i, input int c, input int k);
      int unsigned ws = (i == 0) ? WS0 : WS1;
      int a, s, fin;
      bit e;
      done_t d;
      a = c + 2 + int'(ws);
      s = 0;
      e = 1'b0;
`ifdef MEM_READY_EN
      while (!rdy[a + s] && s < int'(RT)) s++;
      e = !rdy[a + s];
`endif
      fin = a + s + 2;
      for (int t = c + 1; t <= fin; t++) begin
         knd[i][t]  = k;
         erra[i][t] = e;
         if (t == c + 1)        ph[i][t] = P_ADDR;
         else if (t <= a + s)   ph[i][t] = P_ACC;
         else if (t == fin - 1) ph[i][t] = P_LAT;
         else                   ph[i][t] = P_FIN;
      end
      d.cyc = fin; d.kind = k; d.err = e;
      if (i == 0) dq0.push_back(d);
      else        dq1.push_back(d);
   endtask

   task automatic step(input bit r, input logic [1:0] k);
      bus0.Req = r; bus0.ReqKind = k;
      bus1.Req = r; bus1.ReqKind = k;
`ifdef MEM_READY_EN
      bus0.Ready = rdy[cur_cyc];
      bus1.Ready = rdy[cur_cyc];
`endif
      @(posedge clk);
      if (nReset) begin
         for (int i = 0; i < 2; i++)
            if ((ph[i][cur_cyc] == P_IDLE || ph[i][cur_cyc] == P_FIN) && r && k != 2'b11)
               schedule(i, cur_cyc, int'(k));
      end
      cur_cyc++;
      #1;
   endtask

   task automatic check_done(input int i, input int c, input logic [12:0] v);
      done_t d;
      int gk;
      tests++;
      if ((i == 0 ? dq0.size() : dq1.size()) == 0) begin
         fails++;
         $display("FAIL done%0d unexpected at cyc=%0d got=Done required=no Done", i, c);
      end else begin
         d  = (i == 0) ? dq0.pop_front() : dq1.pop_front();
         gk = v[1] ? 0 : (v[0] ? 1 : 2);
         if (d.cyc != c || d.kind != gk || d.err != v[10]) begin
            fails++;
            $display("FAIL done%0d got cyc=%0d kind=%0d err=%0d required cyc=%0d kind=%0d err=%0d",
                     i, c, gk, v[10], d.cyc, d.kind, d.err);
         end
      end
   endtask

   always @(negedge clk) begin : monitor
      int c;
      logic [12:0] e0, e1;
      c  = cur_cyc;
      e0 = expect_vec(ph[0][c], knd[0][c], erra[0][c]);
      e1 = expect_vec(ph[1][c], knd[1][c], erra[1][c]);
      tests += 2;
      if (vec0 !== e0) begin
         fails++;
         $display("FAIL outs0 cyc=%0d got=%b required=%b", c, vec0, e0);
      end
      if (vec1 !== e1) begin
         fails++;
         $display("FAIL outs1 cyc=%0d got=%b required=%b", c, vec1, e1);
      end
      if (vec0[11] === 1'b1) check_done(0, c, vec0);
      if (vec1[11] === 1'b1) check_done(1, c, vec1);
   end

   initial begin
      bus0.Req = 1'b0; bus0.ReqKind = 2'b00;
      bus1.Req = 1'b0; bus1.ReqKind = 2'b00;
      for (int c = 0; c < ASZ; c++)
         rdy[c] = ((c % 60) >= 7) && ($urandom_range(3) != 0);
`ifdef MEM_READY_EN
      bus0.Ready = 1'b1;
      bus1.Ready = 1'b1;
`endif
      repeat (3) @(posedge clk);
      #1 nReset = 1'b1;

      for (int n = 0; n < 500; n++)
         step($urandom_range(3) != 0, 2'($urandom_range(3)));
      repeat (20) step(1'b0, 2'b00);

      // Abort a fetch while both instances sit in ACCESS.
      step(1'b1, 2'b00);
      step(1'b0, 2'b00);
      #1 nReset = 1'b0;
      #1;
      tests += 2;
      if (vec0 !== IDLE_V) begin
         fails++;
         $display("FAIL async_reset0 got=%b required=%b", vec0, IDLE_V);
      end
      if (vec1 !== IDLE_V) begin
         fails++;
         $display("FAIL async_reset1 got=%b required=%b", vec1, IDLE_V);
      end
      for (int t = cur_cyc; t < ASZ; t++) begin
         ph[0][t] = P_IDLE;
         ph[1][t] = P_IDLE;
      end
      dq0.delete();
      dq1.delete();
      repeat (2) step(1'b0, 2'b00);
      nReset = 1'b1;
      repeat (10) step(1'b0, 2'b00);

      tests++;
      if (dq0.size() != 0 || dq1.size() != 0) begin
         fails++;
         $display("FAIL done_drain got pending=%0d/%0d required=0/0", dq0.size(), dq1.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
